// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// ALU control codes and the datapath mux select codes.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_JALR     = 4'd11;
  localparam state_t S_LUI      = 4'd12;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } aluop_e;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         imm_sel = IMM_S;
      OP_BRANCH:        imm_sel = IMM_B;
      OP_JAL:           imm_sel = IMM_J;
      OP_LUI, OP_AUIPC: imm_sel = IMM_U;
      default:          imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_alu_ctrl_dec.sv
// ALU operation decode: maps the aluop class plus funct fields to an alu_ctrl
// code and flags funct3 values this core does not implement.
module alu_ctrl_dec
  import riscv_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  // Branches compare with sub (eq/ne/unsigned) or slt (signed); 010/011 are undefined.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3_i)
          3'b100, 3'b101: alu_ctrl_o = ALU_SLT;
          3'b010, 3'b011: illegal_o  = 1'b1;
          default:        alu_ctrl_o = ALU_SUB;
        endcase
      end
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  illegal_o  = 1'b1;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b111:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and the ALU control code.
module mc_controller
  import riscv_pkg::*;
#(
  parameter logic ADDR_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       Cout,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_ctrl,
  output logic       illegal_instr
);

  state_t     state_q, state_d;
  logic       active_q;
  logic       mem_rdy_s;
  logic [1:0] aluop_s;
  logic       opc_known_s;
  logic [3:0] dec_alu_ctrl_s;
  logic       dec_illegal_s;
  logic       illegal_s;
  logic       taken_s;

  assign mem_rdy_s = ADDR_WAIT ? mem_ready : 1'b1;
  assign illegal_s = !opc_known_s || dec_illegal_s;

  // The decoder class comes from the opcode alone so legality is known in DECODE.
  always_comb begin
    aluop_s     = ALUOP_ADD;
    opc_known_s = 1'b1;
    case (opcode)
      OP_RTYPE, OP_IALU: aluop_s = ALUOP_FUNCT;
      OP_BRANCH:         aluop_s = ALUOP_BRANCH;
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: aluop_s = ALUOP_ADD;
      default:           opc_known_s = 1'b0;
    endcase
  end

  alu_ctrl_dec u_alu_ctrl_dec (
    .aluop_i    (aluop_s),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .op5_i      (opcode[5]),
    .alu_ctrl_o (dec_alu_ctrl_s),
    .illegal_o  (dec_illegal_s)
  );

  // Branch decision; slt leaves zero=1 when rs1 >= rs2, Cout=1 means unsigned >=.
  always_comb begin
    case (funct3)
      3'b000:  taken_s = zero;
      3'b001:  taken_s = !zero;
      3'b100:  taken_s = !zero;
      3'b101:  taken_s = zero;
      3'b110:  taken_s = !Cout;
      3'b111:  taken_s = Cout;
      default: taken_s = 1'b0;
    endcase
  end

  // Next state and outputs; everything stays zero until the first edge after reset.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    imm_src       = IMM_I;
    alu_ctrl      = ALU_ADD;
    illegal_instr = 1'b0;
    if (active_q) begin
      case (state_q)
        S_FETCH: begin
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          pc_write   = mem_rdy_s;
          ir_write   = mem_rdy_s;
          state_d    = mem_rdy_s ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = imm_sel(opcode);
          if (illegal_s) begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end else begin
            case (opcode)
              OP_LOAD, OP_STORE: state_d = S_MEMADR;
              OP_RTYPE:          state_d = S_EXECR;
              OP_IALU:           state_d = S_EXECI;
              OP_BRANCH:         state_d = S_BRANCH;
              OP_JAL:            state_d = S_JAL;
              OP_JALR:           state_d = S_JALR;
              OP_LUI:            state_d = S_LUI;
              OP_AUIPC:          state_d = S_ALUWB;
              default:           state_d = S_FETCH;
            endcase
          end
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = imm_sel(opcode);
          state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          adr_src = 1'b1;
          state_d = mem_rdy_s ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          result_src = RES_RDATA;
          reg_write  = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
          state_d   = mem_rdy_s ? S_FETCH : S_MEMWRITE;
        end
        S_EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_ctrl  = dec_alu_ctrl_s;
          state_d   = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_ctrl  = dec_alu_ctrl_s;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          alu_ctrl  = dec_alu_ctrl_s;
          pc_write  = taken_s;
          state_d   = S_FETCH;
        end
        S_JALR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          state_d   = S_JAL;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
          state_d   = S_ALUWB;
        end
        S_LUI: begin
          result_src = RES_IMM;
          imm_src    = IMM_U;
          reg_write  = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end else begin
      state_d = S_FETCH;
    end
  end

  // State register; active_q delays release so outputs wake at the first edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller: one record per instruction
// with hand-computed cycle count and per-state output expectations.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, Cout, mem_ready;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;

  always #5 clk = ~clk;

  mc_controller #(.ADDR_WAIT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .Cout(Cout), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .illegal_instr(illegal_instr)
  );

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       c;
    int         cyc;     // cycles from FETCH to the next FETCH
    logic [3:0] alu2;    // outputs in the third cycle of the instruction
    logic       pcw2;
    logic [1:0] sa2;
    logic [1:0] sb2;
    int         rw_idx;  // cycle index of the single reg_write, -1 for none
    int         rs_wb;   // result_src in that cycle
    int         pcw_n;   // pc_write cycles after FETCH
    int         mw_n;
    int         ill;
  } vec_t;

  localparam int MAXC = 16;
  logic [3:0] r_alu [0:MAXC];
  logic       r_pcw [0:MAXC];
  logic       r_rw  [0:MAXC];
  logic       r_mw  [0:MAXC];
  logic       r_ill [0:MAXC];
  logic       r_adr [0:MAXC];
  logic [1:0] r_sa  [0:MAXC];
  logic [1:0] r_sb  [0:MAXC];
  logic [1:0] r_rs  [0:MAXC];

  int chk_n = 0;
  int err_n = 0;
  int n_cyc, rw_cnt, rw_idx, pcw_n, mw_n, ill_n;
  vec_t vq[$];

  task automatic check(input string name, input int act, input int exp);
    chk_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction starting in a FETCH cycle; records outputs per cycle.
  task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z, input logic c,
                            input int stall_at, input int stall_n);
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z; Cout = c;
    n_cyc = MAXC;
    for (int k = 0; k <= MAXC; k++) begin
      if (k > 0) @(negedge clk);
      mem_ready = (k >= stall_at && k < stall_at + stall_n) ? 1'b0 : 1'b1;
      #1;
      r_alu[k] = alu_ctrl;  r_pcw[k] = pc_write;  r_rw[k] = reg_write;
      r_mw[k]  = mem_write; r_ill[k] = illegal_instr; r_adr[k] = adr_src;
      r_sa[k]  = alu_src_a; r_sb[k]  = alu_src_b; r_rs[k] = result_src;
      if (k > 0 && ir_write) begin
        n_cyc = k;
        break;
      end
    end
    rw_cnt = 0; rw_idx = -1; pcw_n = 0; mw_n = 0; ill_n = 0;
    for (int k = 1; k < n_cyc; k++) begin
      if (r_rw[k]) begin
        rw_cnt++;
        if (rw_idx < 0) rw_idx = k;
      end
      pcw_n += int'(r_pcw[k]);
      mw_n  += int'(r_mw[k]);
      ill_n += int'(r_ill[k]);
    end
  endtask

  initial begin
    // op, f3, f7, z, c, cyc, alu2, pcw2, sa2, sb2, rw_idx, rs_wb, pcw_n, mw_n, ill
    vq.push_back('{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 4, 4'b0001, 1'b0, 2'b10, 2'b00, 3, 0, 0, 0, 0}); // sub
    vq.push_back('{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 1'b0, 2'b10, 2'b00, 3, 0, 0, 0, 0}); // add
    vq.push_back('{7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 4, 4'b0100, 1'b0, 2'b10, 2'b00, 3, 0, 0, 0, 0}); // sll
    vq.push_back('{7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 4, 4'b0101, 1'b0, 2'b10, 2'b00, 3, 0, 0, 0, 0}); // slt
    vq.push_back('{7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, 4, 4'b0110, 1'b0, 2'b10, 2'b00, 3, 0, 0, 0, 0}); // xor
    vq.push_back('{7'b0110011, 3'b101, 1'b0, 1'b0, 1'b0, 4, 4'b0111, 1'b0, 2'b10, 2'b00, 3, 0, 0, 0, 0}); // srl
    vq.push_back('{7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0, 4, 4'b1000, 1'b0, 2'b10, 2'b00, 3, 0, 0, 0, 0}); // sra
    vq.push_back('{7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 4, 4'b0011, 1'b0, 2'b10, 2'b00, 3, 0, 0, 0, 0}); // or
    vq.push_back('{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 4, 4'b0010, 1'b0, 2'b10, 2'b00, 3, 0, 0, 0, 0}); // and
    vq.push_back('{7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 4, 4'b0000, 1'b0, 2'b10, 2'b01, 3, 0, 0, 0, 0}); // addi, b30 set
    vq.push_back('{7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 4, 4'b1000, 1'b0, 2'b10, 2'b01, 3, 0, 0, 0, 0}); // srai
    vq.push_back('{7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0, 4, 4'b0010, 1'b0, 2'b10, 2'b01, 3, 0, 0, 0, 0}); // andi
    vq.push_back('{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 3, 4'b0001, 1'b1, 2'b10, 2'b00, -1, 0, 1, 0, 0}); // beq z=1
    vq.push_back('{7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 3, 4'b0001, 1'b0, 2'b10, 2'b00, -1, 0, 0, 0, 0}); // bne z=1
    vq.push_back('{7'b1100011, 3'b100, 1'b0, 1'b0, 1'b0, 3, 4'b0101, 1'b1, 2'b10, 2'b00, -1, 0, 1, 0, 0}); // blt z=0
    vq.push_back('{7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 3, 4'b0101, 1'b0, 2'b10, 2'b00, -1, 0, 0, 0, 0}); // bge z=0
    vq.push_back('{7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 3, 4'b0001, 1'b1, 2'b10, 2'b00, -1, 0, 1, 0, 0}); // bltu c=0
    vq.push_back('{7'b1100011, 3'b111, 1'b0, 1'b1, 1'b0, 3, 4'b0001, 1'b0, 2'b10, 2'b00, -1, 0, 0, 0, 0}); // bgeu c=0
    vq.push_back('{7'b1100011, 3'b111, 1'b0, 1'b0, 1'b1, 3, 4'b0001, 1'b1, 2'b10, 2'b00, -1, 0, 1, 0, 0}); // bgeu c=1
    vq.push_back('{7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 3, 4'b0000, 1'b0, 2'b00, 2'b00, 2, 3, 0, 0, 0}); // lui
    vq.push_back('{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 1'b1, 2'b01, 2'b10, 3, 0, 1, 0, 0}); // jal
    vq.push_back('{7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 5, 4'b0000, 1'b0, 2'b10, 2'b01, 4, 0, 1, 0, 0}); // jalr
    vq.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 1'b0, 2'b10, 2'b01, -1, 0, 0, 1, 0}); // sw
    vq.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 5, 4'b0000, 1'b0, 2'b10, 2'b01, 4, 1, 0, 0, 0}); // lw
    vq.push_back('{7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 2'b00, -1, 0, 0, 0, 1}); // 0x7F
    vq.push_back('{7'b0010011, 3'b011, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 2'b00, -1, 0, 0, 0, 1}); // sltiu
    vq.push_back('{7'b0110011, 3'b011, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 2'b00, -1, 0, 0, 0, 1}); // sltu
    vq.push_back('{7'b1100011, 3'b010, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 2'b00, -1, 0, 0, 0, 1}); // branch 010

    reset_n = 1'b0; mem_ready = 1'b1;
    opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; Cout = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("release_before_edge_pc_write", int'(pc_write), 0);
    @(negedge clk); #1;
    check("first_fetch_pc_write", int'(pc_write), 1);
    check("first_fetch_ir_write", int'(ir_write), 1);

    // Walk a load into MEMREAD, then reset in the middle of it.
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1 check("memread_adr_src", int'(adr_src), 1);
    reset_n = 1'b0;
    #1;
    check("rst_pc_write", int'(pc_write), 0);
    check("rst_ir_write", int'(ir_write), 0);
    check("rst_mem_write", int'(mem_write), 0);
    check("rst_reg_write", int'(reg_write), 0);
    check("rst_illegal", int'(illegal_instr), 0);
    check("rst_adr_src", int'(adr_src), 0);
    check("rst_result_src", int'(result_src), 0);
    check("rst_alu_src_a", int'(alu_src_a), 0);
    check("rst_alu_src_b", int'(alu_src_b), 0);
    check("rst_imm_src", int'(imm_src), 0);
    check("rst_alu_ctrl", int'(alu_ctrl), 0);
    @(negedge clk);
    reset_n = 1'b1; mem_ready = 1'b1;
    #1 check("rerelease_pc_write", int'(pc_write), 0);
    @(negedge clk); #1;
    check("post_reset_fetch_pc_write", int'(pc_write), 1);
    check("post_reset_fetch_ir_write", int'(ir_write), 1);

    foreach (vq[i]) begin
      exec_instr(vq[i].op, vq[i].f3, vq[i].f7, vq[i].z, vq[i].c, MAXC + 1, 0);
      check($sformatf("v%0d_cycles", i), n_cyc, vq[i].cyc);
      check($sformatf("v%0d_reg_write_idx", i), rw_idx, vq[i].rw_idx);
      check($sformatf("v%0d_reg_write_cnt", i), rw_cnt, (vq[i].rw_idx >= 0) ? 1 : 0);
      check($sformatf("v%0d_pc_write_cnt", i), pcw_n, vq[i].pcw_n);
      check($sformatf("v%0d_mem_write_cnt", i), mw_n, vq[i].mw_n);
      check($sformatf("v%0d_illegal_cnt", i), ill_n, vq[i].ill);
      check($sformatf("v%0d_illegal_in_decode", i), int'(r_ill[1]), vq[i].ill);
      if (vq[i].cyc > 2) begin
        check($sformatf("v%0d_alu_ctrl", i), int'(r_alu[2]), int'(vq[i].alu2));
        check($sformatf("v%0d_pc_write", i), int'(r_pcw[2]), int'(vq[i].pcw2));
        check($sformatf("v%0d_alu_src_a", i), int'(r_sa[2]), int'(vq[i].sa2));
        check($sformatf("v%0d_alu_src_b", i), int'(r_sb[2]), int'(vq[i].sb2));
      end
      if (vq[i].rw_idx >= 0)
        check($sformatf("v%0d_wb_result_src", i), int'(r_rs[vq[i].rw_idx]), vq[i].rs_wb);
    end

    // Load with mem_ready low for two MEMREAD cycles.
    exec_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3, 2);
    check("lw_stall_cycles", n_cyc, 7);
    check("lw_stall_reg_write_idx", rw_idx, 6);
    check("lw_stall_reg_write_cnt", rw_cnt, 1);
    check("lw_stall_result_src", int'(r_rs[6]), 1);
    check("lw_stall_adr_wait0", int'(r_adr[3]), 1);
    check("lw_stall_adr_wait1", int'(r_adr[4]), 1);
    check("lw_stall_adr_ready", int'(r_adr[5]), 1);
    check("lw_stall_mem_write_cnt", mw_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", chk_n, err_n);
    $finish;
  end

endmodule
